fft_mag_calc: RTL and testbench

//  Converts the complex FFT core output (Avalon-ST real/imag, sop/eop/valid) into a 16-bit

---
 rtl/fft_mag_calc.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fft_mag_calc.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_calc.sv
// fft_mag_calc
// Turns the FFT core's complex output stream into a 16-bit magnitude stream
// (alpha-max-plus-beta-min estimate), checks the input framing and reports
// the strongest bin of the displayed half-spectrum once per frame.
module fft_mag_calc #(
   parameter int TRANSFORM_LEN = 1024,
   parameter int SCALE_SHIFT   = 0
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic [15:0] src_real,
   input  logic [15:0] src_imag,
   input  logic        src_sop,
   input  logic        src_eop,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [15:0] fft_data,
   output logic        fft_sop,
   output logic        fft_eop,
   output logic        fft_valid,
   output logic [9:0]  peak_bin,
   output logic [15:0] peak_mag,
   output logic        peak_valid,
   output logic        frame_err
);

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(TRANSFORM_LEN - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TRANSFORM_LEN / 2 - 1);

   typedef enum logic {
      ST_IDLE,
      ST_IN_FRAME
   } state_t;

   // ------------------------------------------------------------------
   // Input side: ready and framing FSM
   // ------------------------------------------------------------------
   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  in_cnt_reg, in_cnt_next;
   logic              ready_reg;
   logic              accept;
   logic              fwd_valid, fwd_sop, fwd_eop;
   logic              err_next;
   logic              frame_err_reg;

   assign accept = src_valid && ready_reg;

   // Ready rises on the first clock after reset release and stays high
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         ready_reg <= 1'b0;
      end else begin
         ready_reg <= 1'b1;
      end
   end

   // Framing state, bin counter and registered error pulse
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         in_cnt_reg    <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         in_cnt_reg    <= in_cnt_next;
         frame_err_reg <= err_next;
      end
   end

   // Decide whether each accepted sample is forwarded, and with which flags
   always_comb begin
      state_next  = state_reg;
      in_cnt_next = in_cnt_reg;
      fwd_valid   = 1'b0;
      fwd_sop     = 1'b0;
      fwd_eop     = 1'b0;
      err_next    = 1'b0;
      if (accept) begin
         case (state_reg)
            ST_IDLE: begin
               if (src_sop && !src_eop) begin
                  fwd_valid   = 1'b1;
                  fwd_sop     = 1'b1;
                  in_cnt_next = CNT_W'(1);
                  state_next  = ST_IN_FRAME;
               end else begin
                  // no frame open (or degenerate sop+eop): drop it
                  err_next = 1'b1;
               end
            end
            ST_IN_FRAME: begin
               if (src_sop && src_eop) begin
                  err_next   = 1'b1;
                  state_next = ST_IDLE;
               end else if (src_sop) begin
                  // premature sop restarts the frame from bin 0
                  err_next    = 1'b1;
                  fwd_valid   = 1'b1;
                  fwd_sop     = 1'b1;
                  in_cnt_next = CNT_W'(1);
               end else if (src_eop) begin
                  fwd_valid  = 1'b1;
                  fwd_eop    = 1'b1;
                  err_next   = (in_cnt_reg != LAST_BIN);
                  state_next = ST_IDLE;
               end else if (in_cnt_reg == LAST_BIN) begin
                  // last bin arrived without eop: close the frame ourselves
                  fwd_valid  = 1'b1;
                  fwd_eop    = 1'b1;
                  err_next   = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  fwd_valid   = 1'b1;
                  in_cnt_next = in_cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: absolute values, saturating -32768 to 32767
   // ------------------------------------------------------------------
   logic [15:0] src_comp [2];
   logic [14:0] abs_next [2];
   logic [14:0] abs_reg  [2];
   logic        s1_valid_reg, s1_sop_reg, s1_eop_reg;

   assign src_comp[0] = src_real;
   assign src_comp[1] = src_imag;

   for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      assign abs_next[gi] = (src_comp[gi] == 16'h8000) ? 15'h7FFF :
                            src_comp[gi][15] ? 15'(~src_comp[gi] + 16'd1) :
                                               src_comp[gi][14:0];
   end

   // Stage 1 register: magnitudes of both parts plus framing flags
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         abs_reg[0]   <= '0;
         abs_reg[1]   <= '0;
         s1_valid_reg <= 1'b0;
         s1_sop_reg   <= 1'b0;
         s1_eop_reg   <= 1'b0;
      end else begin
         abs_reg[0]   <= abs_next[0];
         abs_reg[1]   <= abs_next[1];
         s1_valid_reg <= fwd_valid;
         s1_sop_reg   <= fwd_sop;
         s1_eop_reg   <= fwd_eop;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: sort into larger / smaller component
   // ------------------------------------------------------------------
   logic [14:0] mx_next, mn_next;
   logic [14:0] mx_reg, mn_reg;
   logic        s2_valid_reg, s2_sop_reg, s2_eop_reg;

   assign mx_next = (abs_reg[0] >= abs_reg[1]) ? abs_reg[0] : abs_reg[1];
   assign mn_next = (abs_reg[0] >= abs_reg[1]) ? abs_reg[1] : abs_reg[0];

   // Stage 2 register: max/min pair plus framing flags
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         mx_reg       <= '0;
         mn_reg       <= '0;
         s2_valid_reg <= 1'b0;
         s2_sop_reg   <= 1'b0;
         s2_eop_reg   <= 1'b0;
      end else begin
         mx_reg       <= mx_next;
         mn_reg       <= mn_next;
         s2_valid_reg <= s1_valid_reg;
         s2_sop_reg   <= s1_sop_reg;
         s2_eop_reg   <= s1_eop_reg;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: mx + 3/8*mn approximation, scale, saturate to 16 bits
   // ------------------------------------------------------------------
   logic [16:0]      raw_sum;
   logic [16:0]      raw_scaled;
   logic [15:0]      mag_sat;
   logic [15:0]      fft_data_reg;
   logic             fft_valid_reg, fft_sop_reg, fft_eop_reg;
   logic [CNT_W-1:0] out_bin_reg;

   assign raw_sum    = {2'b00, mx_reg} + 17'(mn_reg >> 2) + 17'(mn_reg >> 3);
   assign raw_scaled = raw_sum >> SCALE_SHIFT;
   assign mag_sat    = (raw_scaled > 17'h0FFFF) ? 16'hFFFF : raw_scaled[15:0];

   // Stage 3 register: output magnitude, flags and bin index within the frame
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         fft_data_reg  <= '0;
         fft_valid_reg <= 1'b0;
         fft_sop_reg   <= 1'b0;
         fft_eop_reg   <= 1'b0;
         out_bin_reg   <= '0;
      end else begin
         fft_data_reg  <= mag_sat;
         fft_valid_reg <= s2_valid_reg;
         fft_sop_reg   <= s2_sop_reg;
         fft_eop_reg   <= s2_eop_reg;
         if (s2_valid_reg) begin
            out_bin_reg <= s2_sop_reg ? '0 : out_bin_reg + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Peak tracker over bins 1..LEN/2-1 of the output stream
   // ------------------------------------------------------------------
   logic [15:0]      cand_mag_reg, cand_mag_next;
   logic [CNT_W-1:0] cand_bin_reg, cand_bin_next;
   logic             in_search;
   logic             peak_hit;
   logic [CNT_W-1:0] peak_bin_reg;
   logic [15:0]      peak_mag_reg;
   logic             peak_valid_reg;

   assign in_search = fft_valid_reg && (out_bin_reg != '0) && (out_bin_reg <= HALF_LAST);
   assign peak_hit  = fft_valid_reg && !fft_sop_reg && (out_bin_reg == HALF_LAST);

   // Candidate update; strict compare keeps the lowest bin on ties
   always_comb begin
      cand_mag_next = cand_mag_reg;
      cand_bin_next = cand_bin_reg;
      if (fft_valid_reg && fft_sop_reg) begin
         cand_mag_next = '0;
         cand_bin_next = '0;
      end else if (in_search && (fft_data_reg > cand_mag_reg)) begin
         cand_mag_next = fft_data_reg;
         cand_bin_next = out_bin_reg;
      end
   end

   // Candidate registers and the published peak, pulsed after the last searched bin
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         cand_mag_reg   <= '0;
         cand_bin_reg   <= '0;
         peak_bin_reg   <= '0;
         peak_mag_reg   <= '0;
         peak_valid_reg <= 1'b0;
      end else begin
         cand_mag_reg   <= cand_mag_next;
         cand_bin_reg   <= cand_bin_next;
         peak_valid_reg <= peak_hit;
         if (peak_hit) begin
            peak_bin_reg <= cand_bin_next;
            peak_mag_reg <= cand_mag_next;
         end
      end
   end

   assign src_ready  = ready_reg;
   assign fft_data   = fft_data_reg;
   assign fft_sop    = fft_sop_reg;
   assign fft_eop    = fft_eop_reg;
   assign fft_valid  = fft_valid_reg;
   assign peak_bin   = peak_bin_reg;
   assign peak_mag   = peak_mag_reg;
   assign peak_valid = peak_valid_reg;
   assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_fft_mag_calc.sv
// tb_fft_mag_calc
// Random and directed frames against a per-cycle reference timeline built
// from the magnitude, framing and peak rules; one scaled instance checks
// the shift path on the same stimulus.
module tb_fft_mag_calc;

   localparam int LEN  = 1024;
   localparam int HALF = LEN / 2;
   localparam int NCYC = 20000;

   logic        clk_50m = 1'b0;
   logic        rst_n   = 1'b0;
   logic [15:0] src_real = '0, src_imag = '0;
   logic        src_sop = 1'b0, src_eop = 1'b0, src_valid = 1'b0;
   logic        src_ready;
   logic [15:0] fft_data;
   logic        fft_sop, fft_eop, fft_valid;
   logic [9:0]  peak_bin;
   logic [15:0] peak_mag;
   logic        peak_valid, frame_err;
   logic        src_ready_b;
   logic [15:0] fft_data_b;
   logic        fft_sop_b, fft_eop_b, fft_valid_b;
   logic [9:0]  peak_bin_b;
   logic [15:0] peak_mag_b;
   logic        peak_valid_b, frame_err_b;

   fft_mag_calc #(.TRANSFORM_LEN(LEN), .SCALE_SHIFT(0)) dut (
      .clk_50m(clk_50m), .rst_n(rst_n),
      .src_real(src_real), .src_imag(src_imag), .src_sop(src_sop), .src_eop(src_eop),
      .src_valid(src_valid), .src_ready(src_ready),
      .fft_data(fft_data), .fft_sop(fft_sop), .fft_eop(fft_eop), .fft_valid(fft_valid),
      .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid), .frame_err(frame_err)
   );

   fft_mag_calc #(.TRANSFORM_LEN(LEN), .SCALE_SHIFT(1)) dut_b (
      .clk_50m(clk_50m), .rst_n(rst_n),
      .src_real(src_real), .src_imag(src_imag), .src_sop(src_sop), .src_eop(src_eop),
      .src_valid(src_valid), .src_ready(src_ready_b),
      .fft_data(fft_data_b), .fft_sop(fft_sop_b), .fft_eop(fft_eop_b), .fft_valid(fft_valid_b),
      .peak_bin(peak_bin_b), .peak_mag(peak_mag_b), .peak_valid(peak_valid_b), .frame_err(frame_err_b)
   );

   always #5 clk_50m = ~clk_50m;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ready_from = 1 << 30;
   int last_p   = 0;

   // expected outputs, indexed by the clock edge after which they are visible
   bit exp_v [NCYC];
   bit exp_sop [NCYC];
   bit exp_eop [NCYC];
   int exp_data [NCYC];
   bit exp_err [NCYC];
   bit exp_pv [NCYC];
   int exp_pb [NCYC];
   int exp_pm [NCYC];

   // observed outputs, for targeted checks in the scenario tasks
   bit obs_v [NCYC];
   bit obs_sop [NCYC];
   bit obs_eop [NCYC];
   int obs_data [NCYC];
   int obs_data_b [NCYC];
   bit obs_err [NCYC];
   bit obs_pv [NCYC];
   int obs_pb [NCYC];
   int obs_pm [NCYC];

   // reference model state
   bit m_in_frame = 1'b0;
   int m_cnt = 0;
   int m_best = 0;
   int m_best_bin = 0;

   logic [15:0] fr_re [LEN];
   logic [15:0] fr_im [LEN];
   int frame_p [LEN];

   function automatic int sat_abs(input logic signed [15:0] v);
      int x;
      x = v;
      if (x < 0) x = -x;
      if (x > 32767) x = 32767;
      return x;
   endfunction

   function automatic int ref_mag(input logic [15:0] re, input logic [15:0] im);
      int a, b, mx, mn;
      a = sat_abs(re);
      b = sat_abs(im);
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      return mx + mn / 4 + mn / 8;
   endfunction

   // per-cycle scoreboard against the reference timeline
   always @(posedge clk_50m) begin
      cyc = cyc + 1;
      #1;
      if (cyc < NCYC) begin
         obs_v[cyc] = fft_valid; obs_sop[cyc] = fft_sop; obs_eop[cyc] = fft_eop;
         obs_data[cyc] = fft_data; obs_data_b[cyc] = fft_data_b;
         obs_err[cyc] = frame_err; obs_pv[cyc] = peak_valid;
         obs_pb[cyc] = peak_bin; obs_pm[cyc] = peak_mag;
         n_checks++;
         if (src_ready !== (cyc >= ready_from)) begin
            n_fail++;
            $display("FAIL ready cyc=%0d got=%b want=%b", cyc, src_ready, cyc >= ready_from);
         end
         n_checks++;
         if ({fft_valid, fft_sop, fft_eop} !== {exp_v[cyc], exp_sop[cyc], exp_eop[cyc]}) begin
            n_fail++;
            $display("FAIL flags cyc=%0d got v/s/e=%b%b%b want=%b%b%b", cyc, fft_valid, fft_sop,
                     fft_eop, exp_v[cyc], exp_sop[cyc], exp_eop[cyc]);
         end
         if (exp_v[cyc]) begin
            n_checks++;
            if (int'(fft_data) !== exp_data[cyc]) begin
               n_fail++;
               $display("FAIL data cyc=%0d got=%0d want=%0d", cyc, fft_data, exp_data[cyc]);
            end
            n_checks++;
            if (int'(fft_data_b) !== exp_data[cyc] / 2) begin
               n_fail++;
               $display("FAIL data_shift1 cyc=%0d got=%0d want=%0d", cyc, fft_data_b, exp_data[cyc] / 2);
            end
         end
         n_checks++;
         if (frame_err !== exp_err[cyc]) begin
            n_fail++;
            $display("FAIL frame_err cyc=%0d got=%b want=%b", cyc, frame_err, exp_err[cyc]);
         end
         n_checks++;
         if (peak_valid !== exp_pv[cyc]) begin
            n_fail++;
            $display("FAIL peak_valid cyc=%0d got=%b want=%b", cyc, peak_valid, exp_pv[cyc]);
         end
         if (exp_pv[cyc]) begin
            n_checks++;
            if (int'(peak_bin) !== exp_pb[cyc] || int'(peak_mag) !== exp_pm[cyc]) begin
               n_fail++;
               $display("FAIL peak cyc=%0d got bin=%0d mag=%0d want bin=%0d mag=%0d", cyc,
                        peak_bin, peak_mag, exp_pb[cyc], exp_pm[cyc]);
            end
         end
      end
   end

   // drive one accepted-or-dropped sample and extend the reference timeline
   task automatic send(input logic [15:0] re, input logic [15:0] im, input bit sop, input bit eop);
      int p, mag, bin;
      bit fwd, osop, oeop, err;
      @(negedge clk_50m);
      src_real = re; src_imag = im; src_sop = sop; src_eop = eop; src_valid = 1'b1;
      p = cyc + 1;
      last_p = p;
      fwd = 0; osop = 0; oeop = 0; err = 0; bin = 0;
      mag = ref_mag(re, im);
      if (p < ready_from) return;
      if (!m_in_frame) begin
         if (sop && !eop) begin
            fwd = 1; osop = 1; bin = 0; m_cnt = 1; m_in_frame = 1;
         end else begin
            err = 1;
         end
      end else if (sop && eop) begin
         err = 1; m_in_frame = 0;
      end else if (sop) begin
         err = 1; fwd = 1; osop = 1; bin = 0; m_cnt = 1;
      end else begin
         fwd = 1; bin = m_cnt;
         if (eop || m_cnt == LEN - 1) begin
            oeop = 1;
            err = (m_cnt != LEN - 1) || !eop;
            m_in_frame = 0;
         end else begin
            m_cnt++;
         end
      end
      if (p + 3 < NCYC) begin
         exp_v[p+2] = fwd; exp_sop[p+2] = osop; exp_eop[p+2] = oeop;
         exp_data[p+2] = mag; exp_err[p] = err;
         if (fwd) begin
            if (bin == 0) begin
               m_best = 0; m_best_bin = 0;
            end else if (bin < HALF && mag > m_best) begin
               m_best = mag; m_best_bin = bin;
            end
            if (bin == HALF - 1) begin
               exp_pv[p+3] = 1; exp_pb[p+3] = m_best_bin; exp_pm[p+3] = m_best;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_50m);
         src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
         src_real = 16'($urandom); src_imag = 16'($urandom);
      end
   endtask

   task automatic send_frame(input int nb, input int eop_at, input bit gaps);
      for (int b = 0; b < nb; b++) begin
         if (gaps && b > 0 && $urandom_range(0, 7) == 0) idle(1);
         send(fr_re[b], fr_im[b], b == 0, b == eop_at);
         frame_p[b] = last_p;
      end
   endtask

   task automatic fill_zero();
      for (int b = 0; b < LEN; b++) begin
         fr_re[b] = '0; fr_im[b] = '0;
      end
   endtask

   task automatic fill_random(input int lim);
      for (int b = 0; b < LEN; b++) begin
         fr_re[b] = 16'(int'($urandom_range(0, 2 * lim)) - lim);
         fr_im[b] = 16'(int'($urandom_range(0, 2 * lim)) - lim);
      end
   endtask

   task automatic assert_reset(input int hold);
      @(negedge clk_50m);
      rst_n = 1'b0;
      src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
      m_in_frame = 0;
      ready_from = 1 << 30;
      for (int i = cyc + 1; i < NCYC; i++) begin
         exp_v[i] = 0; exp_sop[i] = 0; exp_eop[i] = 0; exp_data[i] = 0;
         exp_err[i] = 0; exp_pv[i] = 0; exp_pb[i] = 0; exp_pm[i] = 0;
      end
      #1;
      n_checks++;
      if (fft_valid !== 1'b0 || fft_data !== 16'd0 || src_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stream got v=%b data=%0d ready=%b want 0/0/0", fft_valid, fft_data, src_ready);
      end
      n_checks++;
      if (peak_mag !== 16'd0 || peak_bin !== 10'd0 || peak_valid !== 1'b0 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_peak got bin=%0d mag=%0d pv=%b err=%b want all 0", peak_bin, peak_mag,
                  peak_valid, frame_err);
      end
      repeat (hold) @(negedge clk_50m);
      rst_n = 1'b1;
      ready_from = cyc + 1;
      idle(3);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_50m);
      assert_reset(2);
      n_checks++;
      if (src_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_release got=%b want=1", src_ready);
      end
   endtask

   task automatic test_known_peak();
      fill_zero();
      fr_re[0] = 16'd3000; fr_im[0] = 16'd4000;
      fr_re[37] = 16'd20000;
      fr_re[900] = 16'd30000;
      send_frame(LEN, LEN - 1, 0);
      idle(6);
      n_checks++;
      if (!obs_v[frame_p[0] + 2] || obs_data[frame_p[0] + 2] !== 5125) begin
         n_fail++;
         $display("FAIL first_bin_mag got v=%b data=%0d want v=1 data=5125", obs_v[frame_p[0] + 2],
                  obs_data[frame_p[0] + 2]);
      end
      n_checks++;
      if (obs_pv[frame_p[HALF - 1] + 2] || !obs_pv[frame_p[HALF - 1] + 3] ||
          obs_pb[frame_p[HALF - 1] + 3] !== 37 || obs_pm[frame_p[HALF - 1] + 3] !== 20000) begin
         n_fail++;
         $display("FAIL known_peak got pv=%b bin=%0d mag=%0d want pv=1 bin=37 mag=20000",
                  obs_pv[frame_p[HALF - 1] + 3], obs_pb[frame_p[HALF - 1] + 3], obs_pm[frame_p[HALF - 1] + 3]);
      end
   endtask

   task automatic test_tie();
      fill_random(800);
      fr_re[37] = 16'(-20000); fr_im[37] = '0;
      fr_re[40] = '0;          fr_im[40] = 16'd20000;
      send_frame(LEN, LEN - 1, 1);
      idle(6);
      n_checks++;
      if (obs_pb[frame_p[HALF - 1] + 3] !== 37 || obs_pm[frame_p[HALF - 1] + 3] !== 20000) begin
         n_fail++;
         $display("FAIL tie_lowest_bin got bin=%0d mag=%0d want bin=37 mag=20000",
                  obs_pb[frame_p[HALF - 1] + 3], obs_pm[frame_p[HALF - 1] + 3]);
      end
   endtask

   task automatic test_saturation();
      fill_random(32768);
      fr_re[5] = 16'h8000; fr_im[5] = 16'h8000;
      send_frame(LEN, LEN - 1, 1);
      idle(6);
      n_checks++;
      if (obs_data[frame_p[5] + 2] !== 45053 || obs_data_b[frame_p[5] + 2] !== 22526) begin
         n_fail++;
         $display("FAIL min_neg_sat got=%0d/%0d want=45053/22526", obs_data[frame_p[5] + 2],
                  obs_data_b[frame_p[5] + 2]);
      end
   endtask

   task automatic test_no_sop();
      int p;
      send(16'd1234, 16'd99, 0, 0);
      p = last_p;
      idle(5);
      n_checks++;
      if (obs_v[p + 2] || !obs_err[p] || obs_err[p + 1]) begin
         n_fail++;
         $display("FAIL orphan_sample got v=%b err=%b,%b want v=0 err=1,0", obs_v[p + 2], obs_err[p],
                  obs_err[p + 1]);
      end
      fill_random(5000);
      send_frame(LEN, LEN - 1, 1);
      idle(6);
   endtask

   task automatic test_early_eop();
      int pulses;
      fill_random(3000);
      send_frame(501, 500, 1);
      idle(10);
      n_checks++;
      if (!obs_eop[frame_p[500] + 2] || !obs_err[frame_p[500]]) begin
         n_fail++;
         $display("FAIL early_eop got eop=%b err=%b want eop=1 err=1", obs_eop[frame_p[500] + 2],
                  obs_err[frame_p[500]]);
      end
      pulses = 0;
      for (int i = frame_p[0]; i <= frame_p[500] + 8; i++) pulses += int'(obs_pv[i]);
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL early_eop_peak got pulses=%0d want 0", pulses);
      end
   endtask

   task automatic test_restart_forced();
      fill_random(30000);
      send_frame(300, -1, 1);
      fill_random(30000);
      send_frame(LEN, -1, 1);
      idle(6);
      n_checks++;
      if (!obs_err[frame_p[0]] || !obs_sop[frame_p[0] + 2]) begin
         n_fail++;
         $display("FAIL sop_restart got err=%b sop=%b want 1/1", obs_err[frame_p[0]], obs_sop[frame_p[0] + 2]);
      end
      n_checks++;
      if (!obs_eop[frame_p[LEN - 1] + 2] || !obs_err[frame_p[LEN - 1]]) begin
         n_fail++;
         $display("FAIL forced_eop got eop=%b err=%b want 1/1", obs_eop[frame_p[LEN - 1] + 2],
                  obs_err[frame_p[LEN - 1]]);
      end
   endtask

   task automatic test_reset_mid();
      fill_random(20000);
      send_frame(200, -1, 0);
      assert_reset(2);
      fill_zero();
      fr_im[100] = 16'(-1234);
      send_frame(LEN, LEN - 1, 0);
      idle(6);
      n_checks++;
      if (!obs_pv[frame_p[HALF - 1] + 3] || obs_pb[frame_p[HALF - 1] + 3] !== 100 ||
          obs_pm[frame_p[HALF - 1] + 3] !== 1234) begin
         n_fail++;
         $display("FAIL after_reset_peak got pv=%b bin=%0d mag=%0d want pv=1 bin=100 mag=1234",
                  obs_pv[frame_p[HALF - 1] + 3], obs_pb[frame_p[HALF - 1] + 3], obs_pm[frame_p[HALF - 1] + 3]);
      end
   endtask

   initial begin
      #(NCYC * 20);
      n_fail++;
      $display("FAIL watchdog cycle budget expired at cyc=%0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      test_reset();
      test_known_peak();
      test_tie();
      test_saturation();
      test_no_sop();
      test_early_eop();
      test_restart_forced();
      test_reset_mid();
      idle(8);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
